pll_lock_monitor: RTL and testbench

Multi-channel, synthesizable PLL lock supervisor for bench and on-chip self-test. It synchronises NUM_CH asynchronous `pll_lock` inputs into the `clk_tb` domain and runs an independent acquisition/hold state machine per channel. Each channel reports lock-acquisition time, a classified error code (timeout, lock lost, glitch) and contributes to a shared saturating error-event counter. It sits beside the PLL instances and feeds the pass/fail result logger.

---
 rtl/pll_lock_monitor_pkg.sv | 16 +
 rtl/pll_lock_monitor_ch.sv | 111 +++++++++++
 rtl/pll_lock_monitor.sv | 82 ++++++++
 tb/tb_pll_lock_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_monitor_pkg.sv
// Shared types for the PLL lock monitor: per-channel FSM states and error codes.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_LOCKED    = 2'b10,
        ST_FAIL      = 2'b11
    } ch_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LOST    = 2'b10;
    localparam logic [1:0] ERR_GLITCH  = 2'b11;

endpackage

// File: rtl/pll_lock_monitor_ch.sv
// One monitored PLL: lock synchroniser, acquisition timer, hold counter and FSM.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | after reset, waiting for the first start
//   ST_WAIT_LOCK | timer running, waiting for synchronised lock
//   ST_LOCKED    | lock seen, hold counter qualifying its stability
//   ST_FAIL      | terminal until next start; err_code says why
module pll_lock_mon_ch
    import pll_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MIN_HOLD    = 16,
    parameter int TW          = 10
) (
    input  logic          clk_tb,
    input  logic          rst_n,
    input  logic          pll_lock,
    input  logic          start,
    output logic          locked,
    output logic          failed,
    output logic          fail_evt,
    output logic [1:0]    err_code,
    output logic [TW-1:0] lock_cyc
);

    localparam int HW = $clog2(MIN_HOLD + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    ch_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] lock_cyc_q, lock_cyc_d;
    logic [1:0]    err_q, err_d;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            hold_q     <= '0;
            lock_cyc_q <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            lock_cyc_q <= lock_cyc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        hold_d     = hold_q;
        lock_cyc_d = lock_cyc_q;
        err_d      = err_q;
        if (start) begin
            state_d    = ST_WAIT_LOCK;
            timer_d    = '0;
            hold_d     = '0;
            lock_cyc_d = '0;
            err_d      = ERR_NONE;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    // lock takes priority over a timeout landing on the same cycle
                    if (lock_s) begin
                        state_d    = ST_LOCKED;
                        lock_cyc_d = timer_q;
                        hold_d     = '0;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_d = ST_FAIL;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s) begin
                        state_d = ST_FAIL;
                        err_d   = (hold_q < HW'(MIN_HOLD)) ? ERR_GLITCH : ERR_LOST;
                    end else if (hold_q < HW'(MIN_HOLD)) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fail_evt = (state_d == ST_FAIL) && (state_q != ST_FAIL);
    assign locked   = (state_q == ST_LOCKED);
    assign failed   = (state_q == ST_FAIL);
    assign err_code = err_q;
    assign lock_cyc = lock_cyc_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: per-channel monitors plus shared
// saturating failure counter and registered done/pass summary.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MIN_HOLD    = 16,
    parameter int CNT_W       = 3,
    localparam int TW         = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                 clk_tb,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    pll_lock,
    input  logic                 start,
    input  logic                 clr,
    output logic [NUM_CH-1:0]    ch_locked,
    output logic [2*NUM_CH-1:0]  ch_err,
    output logic [TW*NUM_CH-1:0] lock_cyc,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 done,
    output logic                 pass
);

    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    logic [NUM_CH-1:0] ch_fail;
    logic [NUM_CH-1:0] fail_evt;
    logic [PW-1:0]     n_evt;
    logic [SW-1:0]     cnt_sum;
    logic [CNT_W-1:0]  err_cnt_d;
    logic              all_settled;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_lock_mon_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .MIN_HOLD    (MIN_HOLD),
            .TW          (TW)
        ) u_ch (
            .clk_tb   (clk_tb),
            .rst_n    (rst_n),
            .pll_lock (pll_lock[g]),
            .start    (start),
            .locked   (ch_locked[g]),
            .failed   (ch_fail[g]),
            .fail_evt (fail_evt[g]),
            .err_code (ch_err[2*g +: 2]),
            .lock_cyc (lock_cyc[TW*g +: TW])
        );
    end

    always_comb begin
        n_evt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_evt = n_evt + PW'(fail_evt[i]);
        end
    end

    // clr applies before this cycle's FAIL entries are added
    always_comb begin
        cnt_sum   = (clr ? '0 : SW'(err_cnt)) + SW'(n_evt);
        err_cnt_d = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    assign all_settled = &(ch_locked | ch_fail);

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            err_cnt <= err_cnt_d;
            done    <= all_settled;
            pass    <= all_settled && !(|ch_fail);
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: table of lock patterns plus
// hand-written sequences for timing, saturation, clear and reset corners.
module tb_pll_lock_monitor;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 3;
    localparam int TIMEOUT_CYC = 1000;
    localparam int MIN_HOLD    = 16;
    localparam int CNT_W       = 3;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                 clk_tb = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    pll_lock;
    logic                 start;
    logic                 clr;
    logic [NUM_CH-1:0]    ch_locked;
    logic [2*NUM_CH-1:0]  ch_err;
    logic [TW*NUM_CH-1:0] lock_cyc;
    logic [CNT_W-1:0]     err_cnt;
    logic                 done;
    logic                 pass;

    always #5 clk_tb = ~clk_tb;

    pll_lock_monitor #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MIN_HOLD    (MIN_HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_tb    (clk_tb),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .start     (start),
        .clr       (clr),
        .ch_locked (ch_locked),
        .ch_err    (ch_err),
        .lock_cyc  (lock_cyc),
        .err_cnt   (err_cnt),
        .done      (done),
        .pass      (pass)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    typedef struct {
        logic [3:0] lock_init;
        logic [3:0] drop_mask;
        int         drop_at;
        logic [7:0] exp_err;
        logic [3:0] exp_locked;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_cmp;
    int   n_fail;
    int   n;
    int   nf;
    int   exp_cnt;

    task automatic expect_range(input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic expect_eq(input logic [31:0] v);
        expect_range(v, v);
    endtask

    task automatic compare(input string name, input logic [31:0] act);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %0d, nothing expected in scoreboard", name, act);
        end else begin
            e = sb.pop_front();
            if (act < e.lo || act > e.hi) begin
                n_fail++;
                $display("FAIL %s: got %0d, want %0d..%0d", name, act, e.lo, e.hi);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic pulse_start(input logic with_clr);
        start = 1'b1;
        clr   = with_clr;
        tick();
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_reset(input logic [3:0] lk);
        pll_lock = lk;
        rst_n    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (SYNC_STAGES + 2) tick();
    endtask

    task automatic wait_any_fail(input logic [7:0] mask);
        n = 0;
        while ((ch_err & mask) == 8'h00 && n < TIMEOUT_CYC + 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        clr      = 1'b0;
        pll_lock = '0;

        vecs[0] = '{4'b1111, 4'b0000, 0,   8'h00, 4'b1111};
        vecs[1] = '{4'b1011, 4'b0000, 0,   8'h10, 4'b1011};
        vecs[2] = '{4'b1111, 4'b0001, 5,   8'h03, 4'b1110};
        vecs[3] = '{4'b1111, 4'b1000, 200, 8'h80, 4'b0111};
        vecs[4] = '{4'b0000, 4'b0000, 0,   8'h55, 4'b0000};

        #3;
        expect_eq(0); compare("rst_ch_locked", 32'(ch_locked));
        expect_eq(0); compare("rst_ch_err", 32'(ch_err));
        expect_eq(0); compare("rst_err_cnt", 32'(err_cnt));
        expect_eq(0); compare("rst_done", 32'(done));
        expect_eq(0); compare("rst_pass", 32'(pass));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            expect_eq(0); compare("rst_lock_cyc", 32'(lock_cyc[TW*ch +: TW]));
        end

        // table-driven lock patterns, each from a fresh reset
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].lock_init);
            nf = 0;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (vecs[v].exp_err[2*ch +: 2] != 2'b00) nf++;
            exp_cnt = (nf > CNT_MAX) ? CNT_MAX : nf;
            expect_eq(32'(vecs[v].exp_err));
            expect_eq(32'(vecs[v].exp_locked));
            expect_eq(32'(exp_cnt));
            expect_eq(1);
            expect_eq((nf == 0) ? 1 : 0);
            for (int ch = 0; ch < NUM_CH; ch++) expect_eq(0);
            pulse_start(1'b0);
            for (int c = 1; c <= TIMEOUT_CYC + 10; c++) begin
                if (c == vecs[v].drop_at) pll_lock = pll_lock & ~vecs[v].drop_mask;
                tick();
            end
            compare("vec_ch_err", 32'(ch_err));
            compare("vec_ch_locked", 32'(ch_locked));
            compare("vec_err_cnt", 32'(err_cnt));
            compare("vec_done", 32'(done));
            compare("vec_pass", 32'(pass));
            for (int ch = 0; ch < NUM_CH; ch++)
                compare("vec_lock_cyc", 32'(lock_cyc[TW*ch +: TW]));
        end

        // clean lock: locks rise 100 cycles after start
        do_reset(4'b0000);
        pulse_start(1'b0);
        repeat (99) tick();
        pll_lock = 4'hF;
        for (int ch = 0; ch < NUM_CH; ch++) expect_range(101, 103);
        n = 0;
        while (ch_locked != 4'hF && n < 20) begin
            tick();
            n++;
        end
        for (int ch = 0; ch < NUM_CH; ch++)
            compare("clean_lock_cyc", 32'(lock_cyc[TW*ch +: TW]));
        expect_eq(0); compare("clean_done_lag", 32'(done));
        tick();
        expect_eq(1); compare("clean_done", 32'(done));
        expect_eq(1); compare("clean_pass", 32'(pass));
        expect_eq(0); compare("clean_err_cnt", 32'(err_cnt));

        // exact timeout latency on ch2
        do_reset(4'b1011);
        pulse_start(1'b0);
        wait_any_fail(8'h30);
        expect_eq(TIMEOUT_CYC); compare("timeout_cycles", 32'(n));
        expect_eq(1); compare("timeout_code", 32'(ch_err[5:4]));
        expect_eq(1); compare("timeout_err_cnt", 32'(err_cnt));
        tick();
        expect_eq(1); compare("timeout_done", 32'(done));
        expect_eq(0); compare("timeout_pass", 32'(pass));

        // four simultaneous timeouts, twice: 0 -> 4 -> 7 and holds
        do_reset(4'b0000);
        pulse_start(1'b0);
        wait_any_fail(8'hFF);
        expect_eq(TIMEOUT_CYC); compare("sat1_cycles", 32'(n));
        expect_eq(4); compare("sat1_err_cnt", 32'(err_cnt));
        expect_eq(32'h55); compare("sat1_codes", 32'(ch_err));
        pulse_start(1'b0);
        expect_eq(0); compare("restart_codes", 32'(ch_err));
        expect_eq(4); compare("restart_err_cnt", 32'(err_cnt));
        wait_any_fail(8'hFF);
        expect_eq(CNT_MAX); compare("sat2_err_cnt", 32'(err_cnt));
        repeat (20) tick();
        expect_eq(CNT_MAX); compare("sat_hold", 32'(err_cnt));

        // clr + start together while saturated
        pulse_start(1'b1);
        expect_eq(0); compare("clrstart_err_cnt", 32'(err_cnt));
        expect_eq(0); compare("clrstart_codes", 32'(ch_err));
        expect_eq(0); compare("clrstart_locked", 32'(ch_locked));
        tick();
        expect_eq(0); compare("clrstart_done", 32'(done));
        wait_any_fail(8'hFF);
        expect_eq(4); compare("post_clr_err_cnt", 32'(err_cnt));

        // clr landing on the same edge as four FAIL entries
        pulse_start(1'b0);
        repeat (TIMEOUT_CYC - 1) tick();
        expect_eq(0); compare("pre_clr_codes", 32'(ch_err));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_eq(4); compare("clr_fail_err_cnt", 32'(err_cnt));
        expect_eq(32'h55); compare("clr_fail_codes", 32'(ch_err));

        // asynchronous reset in the middle of WAIT_LOCK
        pll_lock = 4'b0001;
        repeat (SYNC_STAGES + 2) tick();
        pulse_start(1'b0);
        repeat (500) tick();
        expect_eq(1); compare("midrun_locked", 32'(ch_locked));
        expect_eq(4); compare("midrun_err_cnt", 32'(err_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq(0); compare("arst_ch_locked", 32'(ch_locked));
        expect_eq(0); compare("arst_ch_err", 32'(ch_err));
        expect_eq(0); compare("arst_err_cnt", 32'(err_cnt));
        expect_eq(0); compare("arst_done", 32'(done));
        expect_eq(0); compare("arst_pass", 32'(pass));
        expect_eq(0); compare("arst_lock_cyc0", 32'(lock_cyc[TW-1:0]));
        #1;
        rst_n    = 1'b1;
        pll_lock = 4'b0000;
        repeat (TIMEOUT_CYC + 100) tick();
        expect_eq(0); compare("post_rst_codes", 32'(ch_err));
        expect_eq(0); compare("post_rst_err_cnt", 32'(err_cnt));
        expect_eq(0); compare("post_rst_done", 32'(done));

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
